// File: rtl/imm_packer.sv
// imm_packer: two-stage valid/ready pipeline that scatters an immediate into a RISC-V I/S/B/U/J template and flags unrepresentable values.
module imm_packer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_INS,
  input  logic [31:0]      IN_TYPE,
  input  logic [31:0]      IN_IMM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_INS,
  output logic             OUT_ERR,
  output logic [CNT_W-1:0] ERR_CNT
);
  localparam logic [31:0] TYPE_I = 32'd1;
  localparam logic [31:0] TYPE_S = 32'd2;
  localparam logic [31:0] TYPE_B = 32'd3;
  localparam logic [31:0] TYPE_U = 32'd4;
  localparam logic [31:0] TYPE_J = 32'd5;
  logic [31:0] packed_ins;
  logic        packed_err;
  logic        s1_valid;
  logic [31:0] s1_ins;
  logic        s1_err;
  logic        s1_load;
  logic        s2_load;
  always_comb begin
    packed_ins = IN_INS;
    packed_err = 1'b0;
    case (IN_TYPE)
      TYPE_I: begin
        packed_ins[31:20] = IN_IMM[11:0];
        packed_err = IN_IMM[31:11] != {21{IN_IMM[31]}};
      end
      TYPE_S: begin
        packed_ins[31:25] = IN_IMM[11:5];
        packed_ins[11:7] = IN_IMM[4:0];
        packed_err = IN_IMM[31:11] != {21{IN_IMM[31]}};
      end
      TYPE_B: begin
        packed_ins[31] = IN_IMM[12];
        packed_ins[30:25] = IN_IMM[10:5];
        packed_ins[11:8] = IN_IMM[4:1];
        packed_ins[7] = IN_IMM[11];
        packed_err = (IN_IMM[31:12] != {20{IN_IMM[31]}}) | IN_IMM[0];
      end
      TYPE_U: begin
        packed_ins[31:12] = IN_IMM[31:12];
        packed_err = |IN_IMM[11:0];
      end
      TYPE_J: begin
        packed_ins[31] = IN_IMM[20];
        packed_ins[30:21] = IN_IMM[10:1];
        packed_ins[20] = IN_IMM[11];
        packed_ins[19:12] = IN_IMM[19:12];
        packed_err = (IN_IMM[31:20] != {12{IN_IMM[31]}}) | IN_IMM[0];
      end
      default: ;
    endcase
  end
  assign s2_load  = !OUT_VALID || OUT_READY;
  assign s1_load  = !s1_valid || s2_load;
  assign IN_READY = s1_load;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid  <= 1'b0;
      s1_ins    <= '0;
      s1_err    <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_INS   <= '0;
      OUT_ERR   <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= IN_VALID;
        s1_ins   <= packed_ins;
        s1_err   <= packed_err;
      end
      if (s2_load) begin
        OUT_VALID <= s1_valid;
        OUT_INS   <= s1_ins;
        OUT_ERR   <= s1_err;
      end
      if (OUT_VALID && OUT_READY && OUT_ERR && !(&ERR_CNT))
        ERR_CNT <= ERR_CNT + 1'b1;
    end
  end
endmodule
